// File: rtl/cache_sim.sv
// cache_sim: set-associative cache tag model (valid/dirty/tag/LRU only, no data).
// One access per clock, write-back / write-allocate, LRU replacement, with
// running statistics counters. Hit/miss and counters update at the sampling edge.
// Optional debug outputs are enabled by defining CACHE_SIM_DEBUG_EN.
module cache_sim #(
  parameter int SETS         = 16,
  parameter int ASSOC        = 2,
  parameter int LINESIZE     = 16,
  parameter int ADDRESS_SIZE = 16,
  localparam int BS_W   = $clog2(LINESIZE),
  localparam int IDX_W  = $clog2(SETS),
  localparam int TAG_W  = ADDRESS_SIZE - IDX_W - BS_W,
  localparam int WAY_W  = (ASSOC > 1) ? $clog2(ASSOC) : 1,
  localparam int IDX_WW = (IDX_W > 0) ? IDX_W : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rw,
  input  logic [ADDRESS_SIZE-1:0] i_address,
  output logic                    o_hit,
  output logic                    o_miss,
  output logic [31:0]             o_accesses,
  output logic [31:0]             o_reads,
  output logic [31:0]             o_writes,
  output logic [31:0]             o_hits,
  output logic [31:0]             o_misses,
  output logic [31:0]             o_evictions,
  output logic [31:0]             o_writebacks
`ifdef CACHE_SIM_DEBUG_EN
  ,
  output logic [IDX_WW-1:0]       o_dbg_index,
  output logic [TAG_W-1:0]        o_dbg_tag,
  output logic [WAY_W-1:0]        o_dbg_way,
  output logic                    o_dbg_evict,
  output logic [TAG_W-1:0]        o_dbg_victim_tag
`endif
);

  // A tag field of zero width means the address cannot hold index + offset.
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("cache_sim: ADDRESS_SIZE too small for SETS and LINESIZE");
  end

  logic             r_valid [SETS][ASSOC];
  logic             r_dirty [SETS][ASSOC];
  logic [TAG_W-1:0] r_tag   [SETS][ASSOC];
  logic [WAY_W-1:0] r_age   [SETS][ASSOC];

  logic        r_hit, r_miss;
  logic [31:0] r_accesses, r_reads, r_writes, r_hits, r_misses, r_evictions, r_writebacks;

  logic [IDX_WW-1:0] w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_inv_found;
  logic [WAY_W-1:0]  w_victim;
  logic [WAY_W-1:0]  w_way;
  logic [WAY_W-1:0]  w_old_age;
  logic              w_victim_valid;
  logic              w_victim_dirty;

  assign w_tag = i_address[ADDRESS_SIZE-1:BS_W+IDX_W];

  if (IDX_W > 0) begin : g_idx
    assign w_idx = i_address[BS_W+IDX_W-1:BS_W];
  end else begin : g_no_idx
    assign w_idx = '0;
  end

  // Byte offset within the line plays no part in the lookup.
  if (BS_W > 0) begin : g_offset
    logic w_unused_offset;
    assign w_unused_offset = ^i_address[BS_W-1:0];
  end

  // Tag match, victim selection and the way touched by this access.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_victim    = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < ASSOC; w++) begin
      if (!r_valid[w_idx][w] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_victim    = WAY_W'(w);
      end
    end
    if (!w_inv_found) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (r_age[w_idx][w] == WAY_W'(ASSOC - 1)) w_victim = WAY_W'(w);
      end
    end
    w_way          = w_hit ? w_hit_way : w_victim;
    w_old_age      = r_age[w_idx][w_way];
    w_victim_valid = r_valid[w_idx][w_victim];
    w_victim_dirty = r_dirty[w_idx][w_victim];
  end

  // Line state, LRU ages, hit/miss flags and statistics counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < ASSOC; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_accesses   <= '0;
      r_reads      <= '0;
      r_writes     <= '0;
      r_hits       <= '0;
      r_misses     <= '0;
      r_evictions  <= '0;
      r_writebacks <= '0;
    end else begin
      r_accesses <= r_accesses + 32'd1;
      if (i_rw) r_writes <= r_writes + 32'd1;
      else      r_reads  <= r_reads + 32'd1;
      r_hit  <= w_hit;
      r_miss <= !w_hit;
      if (w_hit) begin
        r_hits <= r_hits + 32'd1;
        if (i_rw) r_dirty[w_idx][w_way] <= 1'b1;
      end else begin
        r_misses <= r_misses + 32'd1;
        if (w_victim_valid) begin
          r_evictions <= r_evictions + 32'd1;
          if (w_victim_dirty) r_writebacks <= r_writebacks + 32'd1;
        end
        r_valid[w_idx][w_way] <= 1'b1;
        r_tag[w_idx][w_way]   <= w_tag;
        r_dirty[w_idx][w_way] <= i_rw;
      end
      for (int w = 0; w < ASSOC; w++) begin
        if (WAY_W'(w) == w_way)               r_age[w_idx][w] <= '0;
        else if (r_age[w_idx][w] < w_old_age) r_age[w_idx][w] <= r_age[w_idx][w] + WAY_W'(1);
      end
    end
  end

  assign o_hit        = r_hit;
  assign o_miss       = r_miss;
  assign o_accesses   = r_accesses;
  assign o_reads      = r_reads;
  assign o_writes     = r_writes;
  assign o_hits       = r_hits;
  assign o_misses     = r_misses;
  assign o_evictions  = r_evictions;
  assign o_writebacks = r_writebacks;

`ifdef CACHE_SIM_DEBUG_EN
  logic [IDX_WW-1:0] r_dbg_index;
  logic [TAG_W-1:0]  r_dbg_tag;
  logic [WAY_W-1:0]  r_dbg_way;
  logic              r_dbg_evict;
  logic [TAG_W-1:0]  r_dbg_victim_tag;
  logic              w_evict;

  assign w_evict = !w_hit && w_victim_valid;

  // Debug snapshot of the last access, aligned with hit/miss.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dbg_index      <= '0;
      r_dbg_tag        <= '0;
      r_dbg_way        <= '0;
      r_dbg_evict      <= 1'b0;
      r_dbg_victim_tag <= '0;
    end else begin
      r_dbg_index      <= w_idx;
      r_dbg_tag        <= w_tag;
      r_dbg_way        <= w_way;
      r_dbg_evict      <= w_evict;
      r_dbg_victim_tag <= w_evict ? r_tag[w_idx][w_victim] : '0;
    end
  end

  assign o_dbg_index      = r_dbg_index;
  assign o_dbg_tag        = r_dbg_tag;
  assign o_dbg_way        = r_dbg_way;
  assign o_dbg_evict      = r_dbg_evict;
  assign o_dbg_victim_tag = r_dbg_victim_tag;
`endif

endmodule

// File: tb/tb_cache_sim.sv
// Directed bench for cache_sim with default parameters (tag=[15:8], index=[7:4]).
module tb_cache_sim;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rw = 1'b0;
  logic [15:0] address = 16'h0000;
  logic        hit, miss;
  logic [31:0] accesses, reads, writes, hits, misses, evictions, writebacks;
`ifdef CACHE_SIM_DEBUG_EN
  logic [3:0]  dbg_index;
  logic [7:0]  dbg_tag;
  logic [0:0]  dbg_way;
  logic        dbg_evict;
  logic [7:0]  dbg_victim_tag;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cache_sim dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rw         (rw),
    .i_address    (address),
    .o_hit        (hit),
    .o_miss       (miss),
    .o_accesses   (accesses),
    .o_reads      (reads),
    .o_writes     (writes),
    .o_hits       (hits),
    .o_misses     (misses),
    .o_evictions  (evictions),
    .o_writebacks (writebacks)
`ifdef CACHE_SIM_DEBUG_EN
    ,
    .o_dbg_index      (dbg_index),
    .o_dbg_tag        (dbg_tag),
    .o_dbg_way        (dbg_way),
    .o_dbg_evict      (dbg_evict),
    .o_dbg_victim_tag (dbg_victim_tag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eh, input logic em,
                         input int acc, input int rd, input int wr, input int h,
                         input int m, input int ev, input int wb);
    chk({tag, " hit"},        {31'd0, hit},  {31'd0, eh});
    chk({tag, " miss"},       {31'd0, miss}, {31'd0, em});
    chk({tag, " accesses"},   accesses,   acc);
    chk({tag, " reads"},      reads,      rd);
    chk({tag, " writes"},     writes,     wr);
    chk({tag, " hits"},       hits,       h);
    chk({tag, " misses"},     misses,     m);
    chk({tag, " evictions"},  evictions,  ev);
    chk({tag, " writebacks"}, writebacks, wb);
  endtask

  // One access per cycle: drive on the falling edge, sample just after the rising edge.
  task automatic access(input logic rw_i, input logic [15:0] addr);
    @(negedge clk);
    reset   = 1'b0;
    rw      = rw_i;
    address = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    rw      = 1'b1;
    address = 16'hABC0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    access(0, 16'h1230); chk_all("s1 R1230 cold", 0, 1, 1, 1, 0, 0, 1, 0, 0);
    access(0, 16'h1230); chk_all("s2 R1230 hit",  1, 0, 2, 2, 0, 1, 1, 0, 0);
    access(1, 16'h1234); chk_all("s2 W1234 hit",  1, 0, 3, 2, 1, 2, 1, 0, 0);
    access(0, 16'h2230); chk_all("s3 R2230 fill way1", 0, 1, 4, 3, 1, 2, 2, 0, 0);
    access(0, 16'h3230); chk_all("s4 R3230 evict dirty", 0, 1, 5, 4, 1, 2, 3, 1, 1);
    access(0, 16'h1230); chk_all("s5 R1230 evict clean", 0, 1, 6, 5, 1, 2, 4, 2, 1);
    access(0, 16'h1F30); chk_all("s5 R1F30 evict", 0, 1, 7, 6, 1, 2, 5, 3, 1);
    access(0, 16'h1240); chk_all("s5 R1240 other set", 0, 1, 8, 7, 1, 2, 6, 3, 1);
    access(1, 16'h1F38); chk_all("W1F38 hit dirty", 1, 0, 9, 7, 2, 3, 6, 3, 1);
    access(0, 16'h5530); chk_all("R5530 lru victim", 0, 1, 10, 8, 2, 3, 7, 4, 1);
    access(0, 16'h6630); chk_all("R6630 dirty-on-hit wb", 0, 1, 11, 9, 2, 3, 8, 5, 2);
    access(0, 16'h5530); chk_all("R5530 still resident", 1, 0, 12, 10, 2, 4, 8, 5, 2);

    do_reset();
    chk_all("s6 mid reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    access(0, 16'h1230); chk_all("s6 R1230 after reset", 0, 1, 1, 1, 0, 0, 1, 0, 0);
    access(1, 16'h7730); chk_all("W7730 write-allocate", 0, 1, 2, 1, 1, 0, 2, 0, 0);
    access(0, 16'h8830); chk_all("R8830 evict clean", 0, 1, 3, 2, 1, 0, 3, 1, 0);
    access(0, 16'h9930); chk_all("R9930 evict alloc-dirty", 0, 1, 4, 3, 1, 0, 4, 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
